// File: rtl/fp_pkg.sv
// Shared constants and types for the fingerprint SRAM template blocks.
// Template geometry, SRAM layout and reader FSM states.
package fp_pkg;

  localparam int FP_ROWS            = 160;
  localparam int FP_COLS            = 160;
  localparam int FP_WORD_W          = 16;
  localparam int FP_ADDR_W          = 20;
  localparam int FP_SIZE            = 1600;
  localparam int SAVE_BEGIN_ADDRESS = 13000;
  localparam int DB_SIZE_ADDRESS    = 12999;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } fp_rd_state_t;

  function automatic int fp_words(input int rows, input int cols,
                                  input int word_w);
    return rows * cols / word_w;
  endfunction

endpackage

// File: rtl/fp_index_counter.sv
// Row/column/word-index walker over a template, one word per step.
// Column advances by one word; wrapping the last column bumps the row.
module fp_index_counter
  import fp_pkg::*;
#(
  parameter int ROWS   = FP_ROWS,
  parameter int COLS   = FP_COLS,
  parameter int WORD_W = FP_WORD_W,
  parameter int IDX_W  = $clog2(fp_words(ROWS, COLS, WORD_W))
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_index,
  output logic [7:0]       o_row,
  output logic [7:0]       o_col,
  output logic             o_last
);

  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(COLS - WORD_W);
  localparam logic [7:0] STEP     = 8'(WORD_W);

  logic col_wrap;

  assign col_wrap = (o_col == LAST_COL);
  assign o_last   = (o_row == LAST_ROW) && col_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_index <= '0;
      o_row   <= '0;
      o_col   <= '0;
    end else if (i_clr) begin
      o_index <= '0;
      o_row   <= '0;
      o_col   <= '0;
    end else if (i_inc) begin
      o_index <= o_index + 1'b1;
      if (col_wrap) begin
        o_col <= '0;
        o_row <= o_row + 8'd1;
      end else begin
        o_col <= o_col + STEP;
      end
    end
  end

endmodule

// File: rtl/fp_sram_reader.sv
// Streams one stored fingerprint template out of async SRAM word by word.
// Optional running checksum: define FP_SRAM_READER_CHECKSUM_EN.
module fp_sram_reader
  import fp_pkg::*;
#(
  parameter int ROWS   = FP_ROWS,
  parameter int COLS   = FP_COLS,
  parameter int WORD_W = FP_WORD_W,
  parameter int ADDR_W = FP_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_begin_addr,
  output logic              o_sram_req,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [WORD_W-1:0] i_sram_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic [7:0]        o_row,
  output logic [7:0]        o_col,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_finish,
  output logic [WORD_W-1:0] o_checksum
);

  localparam int IDX_W = $clog2(fp_words(ROWS, COLS, WORD_W));

  fp_rd_state_t      state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  index;
  logic              at_last;
  logic              accept;
  logic              beat;
  logic              step;

  assign accept = (state == IDLE) && i_start;
  assign beat   = (state == PRESENT) && o_valid && i_ready && !i_abort;
  assign step   = beat && !at_last;

  fp_index_counter #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_idx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (accept),
    .i_inc   (step),
    .o_index (index),
    .o_row   (o_row),
    .o_col   (o_col),
    .o_last  (at_last)
  );

  // Address wraps modulo 2^ADDR_W; bus is driven only while owned.
  assign o_sram_addr = o_sram_req ? base + ADDR_W'(index) : '0;
  assign o_last      = at_last && o_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      base       <= '0;
      o_sram_req <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_finish   <= 1'b0;
      o_data     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          o_finish <= 1'b0;
          if (i_start) begin
            base       <= i_begin_addr;
            o_sram_req <= 1'b1;
            o_busy     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          o_sram_req <= 1'b0;
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            o_data  <= i_sram_data;
            o_valid <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (i_abort) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            if (at_last) begin
              o_finish <= 1'b1;
              state    <= DONE;
            end else begin
              o_sram_req <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        DONE: begin
          o_finish <= 1'b0;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_SRAM_READER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      csum <= '0;
    else if (accept)
      csum <= '0;
    else if (beat)
      csum <= csum + o_data;
  end

  assign o_checksum = csum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_fp_sram_reader.sv
// Directed bench for fp_sram_reader: full read, stall, abort,
// async reset, address wrap and checksum.
module tb_fp_sram_reader;
  import fp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_abort;
  logic [19:0] i_begin_addr;
  logic        o_sram_req;
  logic [19:0] o_sram_addr;
  logic [15:0] i_sram_data;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic [7:0]  o_row;
  logic [7:0]  o_col;
  logic        o_last;
  logic        o_busy;
  logic        o_finish;
  logic [15:0] o_checksum;

  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_cnt;
  int          fin_cnt;
  int          cyc = 0;
  int          start_cyc;
  int          seq_err;
  logic [19:0] last_addr;
  bit          ones_mode = 1'b0;

  fp_sram_reader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_begin_addr (i_begin_addr),
    .o_sram_req   (o_sram_req),
    .o_sram_addr  (o_sram_addr),
    .i_sram_data  (i_sram_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_finish     (o_finish),
    .o_checksum   (o_checksum)
  );

  always #5 i_clk = ~i_clk;

  assign i_sram_data = ones_mode ? 16'd1 : o_sram_addr[15:0];

  always @(posedge i_clk) begin
    cyc++;
    if (o_valid && i_ready && !i_abort) hs_cnt++;
    if (o_finish) fin_cnt++;
    if (o_sram_req) last_addr = o_sram_addr;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic get_beat(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_rd(input logic [19:0] b);
    @(negedge i_clk);
    start_cyc    = cyc;
    i_begin_addr = b;
    i_start      = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
  endtask

  function automatic int beat_err(input int k, input logic [19:0] b);
    logic [19:0] a;
    a = b + 20'(k);
    if (o_data !== a[15:0] || o_row !== 8'(k / 10) ||
        o_col !== 8'((k % 10) * 16) || last_addr !== a ||
        o_last !== (k == FP_SIZE - 1))
      return 1;
    return 0;
  endfunction

  initial begin
    bit          ok;
    logic [15:0] sd;
    logic [7:0]  sr;
    logic [7:0]  sc;
    logic [15:0] exp_cs;

    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_ready      = 1'b0;
    i_begin_addr = '0;
    repeat (3) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_req", 32'(o_sram_req), 32'd0);
    check("rst_rowcol", {16'd0, o_row, o_col}, 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    i_rst = 1'b0;

    // Full read with ready held high
    hs_cnt  = 0;
    fin_cnt = 0;
    seq_err = 0;
    i_ready = 1'b1;
    start_rd(20'(SAVE_BEGIN_ADDRESS));
    for (int k = 0; k < FP_SIZE; k++) begin
      get_beat(ok);
      if (!ok) break;
      seq_err += beat_err(k, 20'(SAVE_BEGIN_ADDRESS));
      if (k == 0) begin
        check("b0_data", 32'(o_data), 32'h32C8);
        check("b0_rowcol", {16'd0, o_row, o_col}, 32'd0);
      end
      if (k == 10) begin
        check("b10_rowcol", {16'd0, o_row, o_col}, {16'd0, 8'd1, 8'd0});
        check("b10_addr", 32'(last_addr), 32'd13010);
      end
      if (k == 1598) check("b1598_last", 32'(o_last), 32'd0);
      if (k == 1599) begin
        check("b1599_rowcol", {16'd0, o_row, o_col}, {16'd0, 8'd159, 8'd144});
        check("b1599_last", 32'(o_last), 32'd1);
        check("b1599_addr", 32'(last_addr), 32'd14599);
        check("latency", 32'(cyc - start_cyc), 32'd3200);
      end
    end
    check("full_seq", 32'(seq_err), 32'd0);
    for (int i = 0; i < 10 && o_busy; i++) @(negedge i_clk);
    check("full_idle", 32'(o_busy), 32'd0);
    check("full_finish_cnt", 32'(fin_cnt), 32'd1);
    check("full_beats", 32'(hs_cnt), 32'd1600);

    // Backpressure at beat 3, then abort at beat 100
    hs_cnt  = 0;
    fin_cnt = 0;
    seq_err = 0;
    i_ready = 1'b0;
    start_rd(20'(SAVE_BEGIN_ADDRESS));
    for (int k = 0; k <= 100; k++) begin
      get_beat(ok);
      if (!ok) break;
      seq_err += beat_err(k, 20'(SAVE_BEGIN_ADDRESS));
      if (k == 3) begin
        sd = o_data;
        sr = o_row;
        sc = o_col;
        check("bp_b3_data", 32'(sd), 32'd13003);
        for (int s = 0; s < 5; s++) begin
          i_start = (s == 1);
          @(negedge i_clk);
          check("bp_data", 32'(o_data), 32'(sd));
          check("bp_rowcol", {16'd0, o_row, o_col}, {16'd0, sr, sc});
          check("bp_valid_req", {30'd0, o_valid, o_sram_req}, 32'd2);
        end
        i_start = 1'b0;
      end
      if (k < 100) begin
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
      end else begin
        i_ready = 1'b1;
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        i_ready = 1'b0;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
      end
    end
    check("bp_seq", 32'(seq_err), 32'd0);
    repeat (10) @(negedge i_clk);
    check("abort_no_finish", 32'(fin_cnt), 32'd0);
    check("abort_beats", 32'(hs_cnt), 32'd100);

    i_ready = 1'b1;
    start_rd(20'(SAVE_BEGIN_ADDRESS));
    get_beat(ok);
    check("restart_data", 32'(o_data), 32'h32C8);
    check("restart_rowcol", {16'd0, o_row, o_col}, 32'd0);
    do_abort();

    // Asynchronous reset in the middle of a fetch
    start_rd(20'(SAVE_BEGIN_ADDRESS));
    get_beat(ok);
    get_beat(ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_sram_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("arst_in_fetch", 32'(ok), 32'd1);
    check("arst_pre_col", 32'(o_col), 32'd32);
    #2 i_rst = 1'b1;
    #1;
    check("arst_req_valid", {30'd0, o_sram_req, o_valid}, 32'd0);
    check("arst_addr", 32'(o_sram_addr), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_rowcol", {16'd0, o_row, o_col}, 32'd0);
    check("arst_data", 32'(o_data), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Address wrap past the top of the SRAM
    start_rd(20'hFFFF0);
    for (int k = 0; k <= 16; k++) begin
      get_beat(ok);
      if (!ok) break;
      if (k == 15) check("wrap_b15_addr", 32'(last_addr), 32'hFFFFF);
      if (k == 16) begin
        check("wrap_b16_addr", 32'(last_addr), 32'h00000);
        check("wrap_b16_data", 32'(o_data), 32'h0000);
      end
    end
    do_abort();

    // Checksum over a template of all-ones words
    ones_mode = 1'b1;
`ifdef FP_SRAM_READER_CHECKSUM_EN
    exp_cs = 16'h0640;
`else
    exp_cs = 16'h0000;
`endif
    start_rd(20'(SAVE_BEGIN_ADDRESS));
    for (int k = 0; k < FP_SIZE; k++) begin
      get_beat(ok);
      if (!ok) break;
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_finish) begin
        ok = 1'b1;
        break;
      end
    end
    check("cs_finish_seen", 32'(ok), 32'd1);
    check("cs_at_finish", 32'(o_checksum), 32'(exp_cs));
    repeat (3) @(negedge i_clk);
    check("cs_held", 32'(o_checksum), 32'(exp_cs));
    ones_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
